ifm_bank_loader: RTL



---
 rtl/ifm_bank_loader.sv | 100 ++++++++++
 1 files changed

// File: rtl/ifm_bank_loader.sv
// ifm_bank_loader: streams NUM_BANK*WORDS_PER_BANK words into one-hot IFM banks, then starts and tracks one layer run
module ifm_bank_loader #(
    parameter int NUM_BANK       = 16,
    parameter int WORDS_PER_BANK = 128,
    parameter int ADDR_W         = 9,
    parameter int DATA_W         = 128
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                iLoadStart,
    input  logic [1:0]          iLayerInfo,
    input  logic                iAbort,
    input  logic [DATA_W-1:0]   iS_data,
    input  logic                iS_valid,
    output logic                oS_ready,
    output logic [NUM_BANK-1:0] o_ena,
    output logic [NUM_BANK-1:0] o_wea,
    output logic [ADDR_W-1:0]   o_addra,
    output logic [DATA_W-1:0]   o_dia,
    output logic [1:0]          o_layerInfo,
    output logic                oStart,
    input  logic                iLayerDone,
    output logic                oBusy,
    output logic                oDone
);
    localparam int BW = NUM_BANK > 1 ? $clog2(NUM_BANK) : 1;
    localparam int AW = WORDS_PER_BANK > 1 ? $clog2(WORDS_PER_BANK) : 1;

    typedef enum logic [2:0] {IDLE, LOAD, FLUSH, START, RUN, DONE} state_t;

    state_t        r_state;
    logic [BW-1:0] r_bank;
    logic [AW-1:0] r_addr;
    logic          w_accept;
    logic          w_addr_end;
    logic          w_last;

    assign oS_ready   = r_state == LOAD;
    assign oBusy      = r_state != IDLE;
    assign w_accept   = iS_valid && oS_ready;
    assign w_addr_end = r_addr == AW'(WORDS_PER_BANK - 1);
    assign w_last     = w_addr_end && r_bank == BW'(NUM_BANK - 1);

    // Control FSM with registered write strobes, start and done pulses; abort outranks everything
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= IDLE;
            r_bank      <= '0;
            r_addr      <= '0;
            o_ena       <= '0;
            o_wea       <= '0;
            o_addra     <= '0;
            o_dia       <= '0;
            o_layerInfo <= '0;
            oStart      <= 1'b0;
            oDone       <= 1'b0;
        end else if (iAbort) begin
            r_state <= IDLE;
            r_bank  <= '0;
            r_addr  <= '0;
            o_ena   <= '0;
            o_wea   <= '0;
            oStart  <= 1'b0;
            oDone   <= 1'b0;
        end else begin
            o_ena  <= '0;
            o_wea  <= '0;
            oStart <= 1'b0;
            oDone  <= 1'b0;
            case (r_state)
                IDLE: if (iLoadStart) begin
                    r_state     <= LOAD;
                    r_bank      <= '0;
                    r_addr      <= '0;
                    o_layerInfo <= iLayerInfo;
                end
                LOAD: if (w_accept) begin
                    o_ena   <= NUM_BANK'(1) << r_bank;
                    o_wea   <= NUM_BANK'(1) << r_bank;
                    o_addra <= ADDR_W'(r_addr);
                    o_dia   <= iS_data;
                    r_addr  <= w_addr_end ? '0 : r_addr + AW'(1);
                    r_bank  <= w_addr_end ? r_bank + BW'(1) : r_bank;
                    r_state <= w_last ? FLUSH : LOAD;
                end
                FLUSH: begin
                    r_state <= START;
                    oStart  <= 1'b1;
                end
                START: r_state <= RUN;
                RUN: if (iLayerDone) begin
                    r_state <= DONE;
                    oDone   <= 1'b1;
                end
                DONE: r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
